// File: rtl/spi_pkg.sv
// Shared types and helpers for the multi-lane SPI transmit path.
// Also reused by the RX-side loopback checker.
package spi_pkg;

    typedef enum logic [1:0] {
        SPI_SINGLE = 2'd0,
        SPI_DUAL   = 2'd1,
        SPI_QUAD   = 2'd2,
        SPI_RSVD   = 2'd3
    } spi_mode_e;

    typedef enum logic {
        TX_IDLE     = 1'b0,
        TX_TRANSMIT = 1'b1
    } spi_tx_state_e;

    // Reserved mode behaves as single lane.
    function automatic logic [2:0] lanes_per_mode(input spi_mode_e mode);
        case (mode)
            SPI_DUAL: return 3'd2;
            SPI_QUAD: return 3'd4;
            default:  return 3'd1;
        endcase
    endfunction

    function automatic logic [1:0] lanes_log2(input spi_mode_e mode);
        case (mode)
            SPI_DUAL: return 2'd1;
            SPI_QUAD: return 2'd2;
            default:  return 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/spi_tx_lane_map.sv
// Maps the edge nibbles of the shift register onto the four SDO lanes
// according to lane mode and bit ordering; unused lanes drive 0.
module spi_tx_lane_map
    import spi_pkg::*;
(
    input  logic [3:0] i_msb_nib,
    input  logic [3:0] i_lsb_nib,
    input  spi_mode_e  i_mode,
    input  logic       i_lsb_first,
    output logic [3:0] o_sdo
);

    always_comb begin
        o_sdo = 4'b0000;
        if (i_lsb_first) begin
            case (i_mode)
                SPI_QUAD: o_sdo      = i_lsb_nib;
                SPI_DUAL: o_sdo[1:0] = i_lsb_nib[1:0];
                default:  o_sdo[0]   = i_lsb_nib[0];
            endcase
        end else begin
            case (i_mode)
                SPI_QUAD: o_sdo      = i_msb_nib;
                SPI_DUAL: o_sdo[1:0] = i_msb_nib[3:2];
                default:  o_sdo[0]   = i_msb_nib[3];
            endcase
        end
    end

endmodule

// File: rtl/spi_tx_multi.sv
// SPI master transmit engine: serialises DATA_W-bit words over 1/2/4 lanes,
// refilling from a valid/ready source and flagging missed refills.
module spi_tx_multi
    import spi_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              tx_edge,
    input  logic [1:0]        mode_in,
    input  logic              lsb_first_in,
    input  logic [CNT_W-1:0]  counter_in,
    input  logic              counter_in_upd,
    input  logic [DATA_W-1:0] data,
    input  logic              data_valid,
    output logic              data_ready,
    output logic [3:0]        sdo,
    output logic              clk_en_o,
    output logic              tx_done,
    output logic              tx_underrun,
    output logic              busy
);

    localparam int unsigned WB_W = $clog2(DATA_W);
    localparam logic [WB_W-1:0] BPW1_M1 = WB_W'(DATA_W - 1);
    localparam logic [WB_W-1:0] BPW2_M1 = WB_W'(DATA_W / 2 - 1);
    localparam logic [WB_W-1:0] BPW4_M1 = WB_W'(DATA_W / 4 - 1);

    spi_tx_state_e     r_state;
    spi_tx_state_e     w_state_next;
    logic [DATA_W-1:0] r_shift;
    spi_mode_e         r_mode;
    logic              r_lsb_first;
    logic [CNT_W-1:0]  r_beat;
    logic [WB_W-1:0]   r_wbeat;
    logic [CNT_W-1:0]  r_target;

    logic [2:0]        w_lanes;
    logic [WB_W-1:0]   w_bpw_m1;
    logic              w_done;
    logic              w_boundary;
    logic              w_load;
    logic              w_advance;
    logic              w_clr_beat;
    logic              w_clr_wbeat;

    assign w_lanes = lanes_per_mode(r_mode);

    always_comb begin
        case (r_mode)
            SPI_QUAD: w_bpw_m1 = BPW4_M1;
            SPI_DUAL: w_bpw_m1 = BPW2_M1;
            default:  w_bpw_m1 = BPW1_M1;
        endcase
    end

    assign w_done     = (r_beat == r_target - CNT_W'(1));
    assign w_boundary = (r_wbeat == w_bpw_m1);
    assign busy       = (r_state == TX_TRANSMIT);

    always_comb begin
        w_state_next = r_state;
        data_ready   = 1'b0;
        clk_en_o     = 1'b0;
        tx_done      = 1'b0;
        tx_underrun  = 1'b0;
        w_load       = 1'b0;
        w_advance    = 1'b0;
        w_clr_beat   = 1'b0;
        w_clr_wbeat  = 1'b0;
        case (r_state)
            TX_IDLE: begin
                if (en && data_valid && (r_target != '0)) begin
                    data_ready   = 1'b1;
                    w_load       = 1'b1;
                    w_clr_beat   = 1'b1;
                    w_clr_wbeat  = 1'b1;
                    w_state_next = TX_TRANSMIT;
                end
            end
            TX_TRANSMIT: begin
                clk_en_o = 1'b1;
                if (tx_edge) begin
                    w_advance = 1'b1;
                    // Done wins over a coincident word boundary.
                    if (w_done) begin
                        tx_done     = 1'b1;
                        w_clr_beat  = 1'b1;
                        w_clr_wbeat = 1'b1;
                        if (en && data_valid) begin
                            data_ready = 1'b1;
                            w_load     = 1'b1;
                        end else begin
                            clk_en_o     = 1'b0;
                            w_state_next = TX_IDLE;
                        end
                    end else if (w_boundary) begin
                        if (data_valid) begin
                            data_ready  = 1'b1;
                            w_load      = 1'b1;
                            w_clr_wbeat = 1'b1;
                        end else begin
                            tx_underrun  = 1'b1;
                            clk_en_o     = 1'b0;
                            w_state_next = TX_IDLE;
                        end
                    end
                end
            end
            default: w_state_next = TX_IDLE;
        endcase
        // The FIFO must never see an accept while the engine is held in reset.
        if (rst) begin
            data_ready = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= TX_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_shift     <= '0;
            r_mode      <= SPI_SINGLE;
            r_lsb_first <= 1'b0;
            r_beat      <= '0;
            r_wbeat     <= '0;
            r_target    <= CNT_W'(8);
        end else begin
            if (w_load) begin
                r_shift     <= data;
                r_mode      <= spi_mode_e'(mode_in);
                r_lsb_first <= lsb_first_in;
            end else if (w_advance) begin
                r_shift <= r_lsb_first ? (r_shift >> w_lanes) : (r_shift << w_lanes);
            end

            if (w_clr_beat) begin
                r_beat <= '0;
            end else if (w_advance) begin
                r_beat <= r_beat + CNT_W'(1);
            end

            if (w_clr_wbeat) begin
                r_wbeat <= '0;
            end else if (w_advance) begin
                r_wbeat <= r_wbeat + WB_W'(1);
            end

            // Target uses the mode presented alongside the update, not the latched one.
            if ((r_state == TX_IDLE) && counter_in_upd) begin
                r_target <= counter_in >> lanes_log2(spi_mode_e'(mode_in));
            end
        end
    end

    spi_tx_lane_map u_lane_map (
        .i_msb_nib   (r_shift[DATA_W-1 -: 4]),
        .i_lsb_nib   (r_shift[3:0]),
        .i_mode      (r_mode),
        .i_lsb_first (r_lsb_first),
        .o_sdo       (sdo)
    );

endmodule

// File: tb/tb_spi_tx_multi.sv
// Directed bench for spi_tx_multi: hand-computed lane sequences, refill,
// underrun, in-flight config isolation, zero target and mid-transfer reset.
module tb_spi_tx_multi;

    logic        clk;
    logic        rst;
    logic        en;
    logic        tx_edge;
    logic [1:0]  mode_in;
    logic        lsb_first_in;
    logic [15:0] counter_in;
    logic        counter_in_upd;
    logic [31:0] data;
    logic        data_valid;
    logic        data_ready;
    logic [3:0]  sdo;
    logic        clk_en_o;
    logic        tx_done;
    logic        tx_underrun;
    logic        busy;

    logic [1:0]  n_mode;
    logic        n_lsb;
    logic [15:0] n_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    spi_tx_multi #(
        .DATA_W (32),
        .CNT_W  (16)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .en             (en),
        .tx_edge        (tx_edge),
        .mode_in        (mode_in),
        .lsb_first_in   (lsb_first_in),
        .counter_in     (counter_in),
        .counter_in_upd (counter_in_upd),
        .data           (data),
        .data_valid     (data_valid),
        .data_ready     (data_ready),
        .sdo            (sdo),
        .clk_en_o       (clk_en_o),
        .tx_done        (tx_done),
        .tx_underrun    (tx_underrun),
        .busy           (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Packed view {sdo, data_ready, tx_done, tx_underrun, clk_en_o, busy}.
    function automatic logic [8:0] pk(input logic [3:0] s, input logic r, input logic d,
                                      input logic u, input logic c, input logic b);
        return {s, r, d, u, c, b};
    endfunction

    function automatic logic [8:0] obs();
        return pk(sdo, data_ready, tx_done, tx_underrun, clk_en_o, busy);
    endfunction

    task automatic check(input string tag, input logic [8:0] got, input logic [8:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: {sdo,rdy,done,ur,clken,busy} observed %b expected %b", tag, got, exp);
        end
    endtask

    // One cycle: inputs change at the falling edge, outputs sampled 1ns later.
    task automatic cyc(input logic e, input logic dv, input logic [31:0] d,
                       input logic en_v, input logic upd);
        @(negedge clk);
        tx_edge        = e;
        data_valid     = dv;
        data           = d;
        en             = en_v;
        counter_in_upd = upd;
        mode_in        = n_mode;
        lsb_first_in   = n_lsb;
        counter_in     = n_cnt;
        #1;
    endtask

    localparam logic [8:0] IDLE_OUT = 9'b0;

    initial begin
        logic [7:0]  v8;
        logic [63:0] v64;
        logic [31:0] d32;

        rst = 1'b1;
        en = 1'b1; data_valid = 1'b1; data = 32'hFFFF_FFFF; tx_edge = 1'b1;
        mode_in = 2'd0; lsb_first_in = 1'b0; counter_in = 16'd0; counter_in_upd = 1'b0;
        n_mode = 2'd0; n_lsb = 1'b0; n_cnt = 16'd0;
        @(negedge clk);
        @(negedge clk);
        #1;
        check("reset_outs", obs(), IDLE_OUT);
        @(negedge clk);
        rst = 1'b0; en = 1'b0; data_valid = 1'b0; tx_edge = 1'b0;

        // Test 1: single MSB-first, 8 bits of 0xA5000000
        n_mode = 2'd0; n_lsb = 1'b0; n_cnt = 16'd8;
        cyc(0, 0, 32'h0, 0, 1);
        check("t1_idle_upd", obs(), IDLE_OUT);
        cyc(0, 1, 32'hA500_0000, 1, 0);
        check("t1_accept", obs(), pk(4'h0, 1, 0, 0, 0, 0));
        v8 = 8'hA5;
        for (int k = 0; k < 8; k++) begin
            cyc(1, 0, 32'h0, 1, 0);
            check($sformatf("t1_edge%0d", k), obs(), pk({3'b0, v8[7-k]}, 0, k == 7, 0, k != 7, 1));
        end
        cyc(0, 0, 32'h0, 0, 0);
        check("t1_after", obs(), IDLE_OUT);

        // Test 2: quad, 64 bits over two words with a refill on the 8th edge
        n_mode = 2'd2; n_cnt = 16'd64;
        cyc(0, 0, 32'h0, 0, 1);
        cyc(0, 1, 32'h1234_5678, 1, 0);
        check("t2_accept", obs(), pk(4'h0, 1, 0, 0, 0, 0));
        v64 = 64'h1234_5678_9ABC_DEF0;
        for (int k = 0; k < 16; k++) begin
            cyc(0, k == 7, 32'h9ABC_DEF0, 1, 0);
            check($sformatf("t2_hold%0d", k), obs(), pk(4'(v64 >> (60 - 4 * k)), 0, 0, 0, 1, 1));
            cyc(1, k == 7, 32'h9ABC_DEF0, 1, 0);
            check($sformatf("t2_edge%0d", k), obs(),
                  pk(4'(v64 >> (60 - 4 * k)), k == 7, k == 15, 0, k != 15, 1));
        end
        cyc(0, 0, 32'h0, 0, 0);
        check("t2_after", obs(), IDLE_OUT);

        // Test 3: dual LSB-first, 8 bits of 0xE4
        n_mode = 2'd1; n_lsb = 1'b1; n_cnt = 16'd8;
        cyc(0, 0, 32'h0, 0, 1);
        cyc(0, 1, 32'h0000_00E4, 1, 0);
        check("t3_accept", obs(), pk(4'h0, 1, 0, 0, 0, 0));
        v8 = 8'hE4;
        for (int k = 0; k < 4; k++) begin
            cyc(1, 0, 32'h0, 1, 0);
            check($sformatf("t3_edge%0d", k), obs(),
                  pk({2'b00, 2'(v8 >> (2 * k))}, 0, k == 3, 0, k != 3, 1));
        end
        cyc(0, 0, 32'h0, 0, 0);
        check("t3_after", obs(), IDLE_OUT);

        // Test 4: single, 64-bit target but only one word -> underrun on 32nd edge
        n_mode = 2'd0; n_lsb = 1'b0; n_cnt = 16'd64;
        cyc(0, 0, 32'h0, 0, 1);
        d32 = 32'hC3A5_5A3C;
        cyc(0, 1, d32, 1, 0);
        check("t4_accept", obs(), pk(4'h0, 1, 0, 0, 0, 0));
        for (int k = 0; k < 32; k++) begin
            cyc(1, 0, 32'h0, 1, 0);
            check($sformatf("t4_edge%0d", k), obs(), pk({3'b0, d32[31-k]}, 0, 0, k == 31, k != 31, 1));
        end
        cyc(0, 0, 32'h0, 0, 0);
        check("t4_after", obs(), IDLE_OUT);

        // Test 5: config changes mid-transfer are ignored; zero target blocks start
        n_mode = 2'd0; n_lsb = 1'b0; n_cnt = 16'd32;
        cyc(0, 0, 32'h0, 0, 1);
        d32 = 32'h0F00_00F1;
        cyc(0, 1, d32, 1, 0);
        check("t5_accept", obs(), pk(4'h0, 1, 0, 0, 0, 0));
        for (int k = 0; k < 32; k++) begin
            if (k == 3) begin
                n_mode = 2'd2;
                n_cnt  = 16'd4;
            end
            cyc(1, 0, 32'h0, 1, k == 3);
            check($sformatf("t5_edge%0d", k), obs(), pk({3'b0, d32[31-k]}, 0, k == 31, 0, k != 31, 1));
        end
        n_cnt = 16'd0;
        cyc(0, 0, 32'h0, 0, 1);
        check("t5_zero_upd", obs(), IDLE_OUT);
        for (int k = 0; k < 3; k++) begin
            cyc(0, 1, 32'hFFFF_FFFF, 1, 0);
            check($sformatf("t5_blocked%0d", k), obs(), IDLE_OUT);
        end

        // Test 6: reset on the 5th edge, then default 8-beat target
        n_mode = 2'd0; n_cnt = 16'd16;
        cyc(0, 0, 32'h0, 0, 1);
        cyc(0, 1, 32'hA500_0000, 1, 0);
        check("t6_accept", obs(), pk(4'h0, 1, 0, 0, 0, 0));
        v8 = 8'hA5;
        for (int k = 0; k < 4; k++) begin
            cyc(1, 0, 32'h0, 1, 0);
            check($sformatf("t6_edge%0d", k), obs(), pk({3'b0, v8[7-k]}, 0, 0, 0, 1, 1));
        end
        cyc(1, 1, 32'hFFFF_FFFF, 1, 0);
        rst = 1'b1;
        #1;
        check("t6_rst_outs", obs(), IDLE_OUT);
        @(negedge clk);
        #1;
        check("t6_rst_held", obs(), IDLE_OUT);
        @(negedge clk);
        rst = 1'b0; tx_edge = 1'b0; data_valid = 1'b0; en = 1'b0;
        #1;
        check("t6_released", obs(), IDLE_OUT);
        cyc(0, 1, 32'h5A00_0000, 1, 0);
        check("t6_accept2", obs(), pk(4'h0, 1, 0, 0, 0, 0));
        v8 = 8'h5A;
        for (int k = 0; k < 8; k++) begin
            cyc(1, 0, 32'h0, 1, 0);
            check($sformatf("t6_beat%0d", k), obs(), pk({3'b0, v8[7-k]}, 0, k == 7, 0, k != 7, 1));
        end
        cyc(0, 0, 32'h0, 0, 0);
        check("t6_after", obs(), IDLE_OUT);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/spi_tx_multi.md
# spi_tx_multi

Parametrised SPI master transmit engine, successor to the fixed 32-bit single/quad transmitter. It serialises `DATA_W`-bit words onto 1, 2 or 4 data lanes with MSB- or LSB-first ordering and a programmable total bit count. Mode and ordering are latched per transfer, and a mid-transfer refill miss is reported as an explicit underrun. It sits between the SPI controller's TX FIFO (valid/ready) and the pad-side clock generator, which supplies `tx_edge` and consumes `clk_en_o`.

## Interface
- `DATA_W`, 32: word width; multiple of 4, ≥8.
- `CNT_W`, 16: width of the bit-count input and the beat counter.
- `clk` in 1: single clock.
- `rst` in 1: asynchronous, active-high reset.
- `en` in 1: transfer enable; sampled only when starting or chaining a transfer.
- `tx_edge` in 1: one-cycle strobe; shift point from the clock generator.
- `mode_in` in 2: 0 = single, 1 = dual, 2 = quad, 3 = reserved (treated as single).
- `lsb_first_in` in 1: bit ordering.
- `counter_in` in CNT_W: total bits per transfer.
- `counter_in_upd` in 1: load `counter_in`; honoured in IDLE only.
- `data` in DATA_W: TX word.
- `data_valid` in 1: TX word valid.
- `data_ready` out 1: combinational accept; word consumed when `data_valid && data_ready`.
- `sdo` out 4: lane outputs.
- `clk_en_o` out 1: SPI clock enable.
- `tx_done` out 1: one-cycle pulse on the final edge of a transfer.
- `tx_underrun` out 1: one-cycle pulse when a refill is missed.
- `busy` out 1: high in TRANSMIT.

## Operation
- **Lanes.** L = 1/2/4 from the latched mode; beats per word BPW = DATA_W/L.
- **Target.** Beat target = `counter_in >> log2(L)`, computed with the mode current in the cycle `counter_in_upd` is seen. Low remainder bits are dropped. Reset value of the target is 8.
- **States.** IDLE and TRANSMIT.
- **IDLE.**
  - `clk_en_o` = 0.
  - If `en && data_valid && target != 0`: `data_ready` = 1, load the shift register, latch mode and `lsb_first`, clear the beat and word-beat counters, go to TRANSMIT.
  - A target of 0 never starts a transfer; data is not consumed.
- **TRANSMIT.**
  - `clk_en_o` = 1 except in the exit cycle.
  - On `tx_edge`: shift by L (left for MSB-first, right for LSB-first), increment both counters.
  - **Done** (beat == target−1 on `tx_edge`): pulse `tx_done` and clear the counters.
    - If `en && data_valid`: accept a new word and stay in TRANSMIT. This chained transfer re-latches mode and ordering.
    - Otherwise: `clk_en_o` = 0 and go to IDLE.
  - **Word boundary** (word-beat == BPW−1 on `tx_edge`, not done):
    - If `data_valid`: accept a new word and clear the word-beat counter. `en` is not rechecked here.
    - Otherwise: pulse `tx_underrun`, `clk_en_o` = 0, go to IDLE. The partial transfer is abandoned and `tx_done` never pulses.
  - Done takes priority when both conditions coincide.
- **Lane mapping, MSB-first.**
  - Single: `sdo[0]` = bit W−1.
  - Dual: `sdo[1:0]` = bits W−1:W−2.
  - Quad: `sdo[3:0]` = bits W−1:W−4.
- **Lane mapping, LSB-first.** `sdo[i]` = bit i for i < L.
- Unused lanes drive 0.
- `counter_in_upd`, `mode_in` and `lsb_first_in` changes during TRANSMIT have no effect on the current transfer.

## Timing
- **Reset.** On `rst`, all of the following clear asynchronously: state IDLE, shift register 0, counters 0, target 8, latched mode single, MSB-first.
  - Outputs while reset is asserted: `sdo` = 0, `clk_en_o` = 0, `busy` = 0, `tx_done` = 0, `tx_underrun` = 0, `data_ready` = 0.
  - Reset mid-transfer aborts with no `tx_done`.
- **Start latency.** The word is accepted in cycle 0, and `sdo` presents its first beat in cycle 1. `clk_en_o` and `busy` rise in cycle 1.
- **Refill timing.** `data_ready` is combinational, asserted only in the `tx_edge` cycle of a boundary or done event. The new first beat is on `sdo` in the next cycle, so there is no bubble.
- **Pulses.** `tx_done` and `tx_underrun` are combinational, coincident with the `tx_edge` that causes them.
- The state register updates on the next `clk`.
- **Counters.** The beat counter wraps only via the done clear, never by overflow. The word-beat counter has width clog2(DATA_W).

## Structure
- **Package `spi_pkg`.**
  - `spi_mode_e` enum: `SPI_SINGLE`, `SPI_DUAL`, `SPI_QUAD`, `SPI_RSVD`.
  - `spi_tx_state_e` enum: `TX_IDLE`, `TX_TRANSMIT`.
  - A lanes-per-mode function.
- **Sub-module `spi_tx_lane_map`.** Combinational mapping from shift register, mode and ordering to `sdo[3:0]`. It is reused by the planned RX-side loopback checker.

## Test plan
1. Single, MSB-first, `counter_in` = 8, `data` = 0xA5000000 → `sdo[0]` reads 1,0,1,0,0,1,0,1 over 8 edges; `tx_done` on the 8th edge; `clk_en_o` low in the next cycle.
2. Quad, `counter_in` = 64, words 0x12345678 then 0x9ABCDEF0 → `sdo` nibbles 1,2,…,8,9,A,…,F,0; `data_ready` on the 8th edge; `tx_done` on the 16th.
3. Dual, LSB-first, `counter_in` = 8, `data` = 0x000000E4 → `sdo[1:0]` reads 0,1,2,3.
4. Single, `counter_in` = 64, only one word supplied → `tx_underrun` pulses on the 32nd edge; state IDLE; `tx_done` never pulses.
5. In TRANSMIT, pulse `counter_in_upd` with 4 and toggle `mode_in` to quad → the current 32-bit single transfer completes unchanged. A subsequent IDLE update to 0 blocks the start while `data_valid` is held.
6. Assert `rst` on the 5th edge of test 1 → all outputs 0 immediately. After release, a transfer with the default target runs exactly 8 beats.
